// File: rtl/mem_pkg.sv
// Shared memory-interface definitions used by the core and the dual-port RAM.
// Op encodings travel on the op_* buses of both RAM ports.
package mem_pkg;

    localparam logic [1:0] MEM_READ = 2'b00;
    localparam logic [1:0] MEM_WB   = 2'b01;
    localparam logic [1:0] MEM_WH   = 2'b10;
    localparam logic [1:0] MEM_WW   = 2'b11;

    localparam int WORD_BYTES = 4;

    typedef logic [1:0] mem_op_t;

endpackage

// File: rtl/dpram_lane_mask.sv
// Converts a port's op and low address bits into a byte write-enable mask and
// write data replicated across lanes so every enabled lane sees the right byte.
module dpram_lane_mask
    import mem_pkg::*;
(
    input  logic [1:0]            op_i,
    input  logic [1:0]            lane_i,
    input  logic [31:0]           data_i,
    output logic [WORD_BYTES-1:0] be_o,
    output logic [31:0]           wdata_o
);

    // Replication lets the mask alone pick the lane; no barrel shifter is needed.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0000_0000;
        case (op_i)
            MEM_READ: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0000_0000;
            end
            MEM_WB: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{data_i[7:0]}};
            end
            MEM_WH: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{data_i[15:0]}};
            end
            MEM_WW: begin
                be_o    = 4'b1111;
                wdata_o = data_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/dualport_ram.sv
// True dual-port, byte-addressed, word-organised synchronous RAM.
// Port A feeds instruction fetch, port B serves loads and stores.
module dualport_ram
    import mem_pkg::*;
#(
    parameter int    ADDR_WIDTH = 15,
    parameter int    DATA_WIDTH = 32,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic                  chip_select_a,
    input  logic [1:0]            op_a,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    output logic [DATA_WIDTH-1:0] data_a_o,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic                  chip_select_b,
    input  logic [1:0]            op_b,
    input  logic [DATA_WIDTH-1:0] data_b_i,
    output logic [DATA_WIDTH-1:0] data_b_o
);

    localparam int WORD_AW = ADDR_WIDTH - 2;
    localparam int DEPTH   = 2 ** WORD_AW;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [WORD_AW-1:0]    idx_a_s;
    logic [WORD_AW-1:0]    idx_b_s;
    logic [WORD_BYTES-1:0] be_a_s;
    logic [WORD_BYTES-1:0] be_b_s;
    logic [DATA_WIDTH-1:0] wdata_a_s;
    logic [DATA_WIDTH-1:0] wdata_b_s;
    logic [WORD_BYTES-1:0] we_a_d;
    logic [WORD_BYTES-1:0] we_b_d;
    logic                  rd_a_d;
    logic                  rd_b_d;
    logic [DATA_WIDTH-1:0] data_a_q;
    logic [DATA_WIDTH-1:0] data_b_q;

    assign idx_a_s = addr_a[ADDR_WIDTH-1:2];
    assign idx_b_s = addr_b[ADDR_WIDTH-1:2];

    dpram_lane_mask u_mask_a (
        .op_i    (op_a),
        .lane_i  (addr_a[1:0]),
        .data_i  (data_a_i),
        .be_o    (be_a_s),
        .wdata_o (wdata_a_s)
    );

    dpram_lane_mask u_mask_b (
        .op_i    (op_b),
        .lane_i  (addr_b[1:0]),
        .data_i  (data_b_i),
        .be_o    (be_b_s),
        .wdata_o (wdata_b_s)
    );

    // Access qualification: reset and deselect both block the array.
    always_comb begin
        if (rst || !chip_select_a) begin
            we_a_d = 4'b0000;
            rd_a_d = 1'b0;
        end else begin
            we_a_d = be_a_s;
            rd_a_d = (op_a == MEM_READ);
        end
        if (rst || !chip_select_b) begin
            we_b_d = 4'b0000;
            rd_b_d = 1'b0;
        end else begin
            we_b_d = be_b_s;
            rd_b_d = (op_b == MEM_READ);
        end
    end

    // Port B's assignment is scheduled last, so it wins bytes both ports write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (we_a_d[i]) begin
                mem_q[idx_a_s][8*i +: 8] <= wdata_a_s[8*i +: 8];
            end
            if (we_b_d[i]) begin
                mem_q[idx_b_s][8*i +: 8] <= wdata_b_s[8*i +: 8];
            end
        end
    end

    // Registered read ports; they sample the pre-write contents (read-before-write).
    always_ff @(posedge clk) begin
        if (rst) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            if (rd_a_d) begin
                data_a_q <= mem_q[idx_a_s];
            end
            if (rd_b_d) begin
                data_b_q <= mem_q[idx_b_s];
            end
        end
    end

    assign data_a_o = data_a_q;
    assign data_b_o = data_b_q;

endmodule

// File: tb/tb_dualport_ram.sv
// Directed bench for dualport_ram: a byte-level memory model predicts both
// outputs every cycle, and literal expectations pin key results.
module tb_dualport_ram;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr_a, addr_b;
    logic          cs_a, cs_b;
    logic [1:0]    op_a, op_b;
    logic [31:0]   din_a, din_b;
    logic [31:0]   dout_a, dout_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  mb [int];
    logic [31:0] exp_a = 32'h0, exp_b = 32'h0;
    bit          val_a = 1'b0, val_b = 1'b0;

    always #5 clk = ~clk;

    dualport_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst),
        .addr_a(addr_a), .chip_select_a(cs_a), .op_a(op_a), .data_a_i(din_a), .data_a_o(dout_a),
        .addr_b(addr_b), .chip_select_b(cs_b), .op_b(op_b), .data_b_i(din_b), .data_b_o(dout_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_read(input int addr, output logic [31:0] w, output bit ok);
        int base;
        base = addr & ~3;
        ok = 1'b1;
        w = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (mb.exists(base + i)) w[8*i +: 8] = mb[base + i];
            else ok = 1'b0;
        end
    endtask

    task automatic model_write(input int addr, input logic [1:0] op, input logic [31:0] d);
        int base;
        case (op)
            2'd1: mb[addr] = d[7:0];
            2'd2: begin
                base = addr & ~1;
                mb[base]     = d[7:0];
                mb[base + 1] = d[15:8];
            end
            2'd3: begin
                base = addr & ~3;
                for (int i = 0; i < 4; i++) mb[base + i] = d[8*i +: 8];
            end
            default: ;
        endcase
    endtask

    // Predict the edge from the current inputs: reads see old data, then A writes, then B.
    task automatic model_step();
        logic [31:0] w;
        bit ok;
        if (rst) begin
            exp_a = 32'h0; val_a = 1'b1;
            exp_b = 32'h0; val_b = 1'b1;
        end else begin
            if (cs_a && op_a == 2'd0) begin model_read(int'(addr_a), w, ok); exp_a = w; val_a = ok; end
            if (cs_b && op_b == 2'd0) begin model_read(int'(addr_b), w, ok); exp_b = w; val_b = ok; end
            if (cs_a) model_write(int'(addr_a), op_a, din_a);
            if (cs_b) model_write(int'(addr_b), op_b, din_b);
        end
    endtask

    // One cycle: drive, predict, let the edge happen, compare on the falling edge.
    task automatic tick(input logic r,
                        input logic ca, input logic [1:0] oa, input logic [AW-1:0] aa, input logic [31:0] da,
                        input logic cb, input logic [1:0] ob, input logic [AW-1:0] ab, input logic [31:0] db);
        rst = r;
        cs_a = ca; op_a = oa; addr_a = aa; din_a = da;
        cs_b = cb; op_b = ob; addr_b = ab; din_b = db;
        model_step();
        @(negedge clk);
        if (val_a) check("model_a", dout_a, exp_a);
        if (val_b) check("model_b", dout_b, exp_b);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 2'd0, 15'h0, 32'h0, 1'b0, 2'd0, 15'h0, 32'h0);
    endtask

    initial begin
        tick(1'b1, 1'b0, 2'd0, 15'h0, 32'h0, 1'b0, 2'd0, 15'h0, 32'h0);
        tick(1'b1, 1'b0, 2'd0, 15'h0, 32'h0, 1'b0, 2'd0, 15'h0, 32'h0);
        check("reset_a", dout_a, 32'h0000_0000);
        check("reset_b", dout_b, 32'h0000_0000);

        // Word 0 seeded with the boot instruction, then fetched on port A.
        tick(1'b0, 1'b0, 2'd0, 15'h0, 32'h0, 1'b1, 2'd3, 15'h000, 32'h0000_0013);
        tick(1'b0, 1'b1, 2'd0, 15'h000, 32'h0, 1'b0, 2'd0, 15'h0, 32'h0);
        check("fetch_word0", dout_a, 32'h0000_0013);

        tick(1'b0, 1'b0, 2'd0, 15'h0, 32'h0, 1'b1, 2'd3, 15'h100, 32'hDEAD_BEEF);
        tick(1'b0, 1'b1, 2'd0, 15'h100, 32'h0, 1'b0, 2'd0, 15'h0, 32'h0);
        check("write_word", dout_a, 32'hDEAD_BEEF);

        // Byte and half writes; upper data bits and addr[0] must be ignored.
        tick(1'b0, 1'b0, 2'd0, 15'h0, 32'h0, 1'b1, 2'd1, 15'h102, 32'hFFFF_FF55);
        tick(1'b0, 1'b0, 2'd0, 15'h0, 32'h0, 1'b1, 2'd2, 15'h101, 32'hABCD_1234);
        tick(1'b0, 1'b1, 2'd0, 15'h100, 32'h0, 1'b0, 2'd0, 15'h0, 32'h0);
        check("byte_half", dout_a, 32'hDE55_1234);

        // Read-before-write collision.
        tick(1'b0, 1'b0, 2'd0, 15'h0, 32'h0, 1'b1, 2'd3, 15'h200, 32'h1111_1111);
        tick(1'b0, 1'b1, 2'd0, 15'h200, 32'h0, 1'b1, 2'd3, 15'h200, 32'h2222_2222);
        check("rbw_old", dout_a, 32'h1111_1111);
        tick(1'b0, 1'b1, 2'd0, 15'h200, 32'h0, 1'b0, 2'd0, 15'h0, 32'h0);
        check("rbw_new", dout_a, 32'h2222_2222);

        // Write-write collisions: full overlap, then B overlapping a single byte of A.
        tick(1'b0, 1'b1, 2'd3, 15'h300, 32'hAAAA_AAAA, 1'b1, 2'd3, 15'h300, 32'hBBBB_BBBB);
        tick(1'b0, 1'b0, 2'd0, 15'h0, 32'h0, 1'b1, 2'd0, 15'h300, 32'h0);
        check("ww_collide", dout_b, 32'hBBBB_BBBB);
        tick(1'b0, 1'b1, 2'd3, 15'h304, 32'hAAAA_AAAA, 1'b1, 2'd1, 15'h305, 32'h0000_00CC);
        tick(1'b0, 1'b1, 2'd0, 15'h304, 32'h0, 1'b0, 2'd0, 15'h0, 32'h0);
        check("partial_collide", dout_a, 32'hAAAA_CCAA);

        // Port A upper-half and top-byte writes.
        tick(1'b0, 1'b1, 2'd2, 15'h303, 32'h0000_5678, 1'b0, 2'd0, 15'h0, 32'h0);
        tick(1'b0, 1'b1, 2'd1, 15'h203, 32'h0000_0077, 1'b1, 2'd0, 15'h300, 32'h0);
        check("half_upper", dout_b, 32'h5678_BBBB);
        tick(1'b0, 1'b0, 2'd0, 15'h0, 32'h0, 1'b1, 2'd0, 15'h200, 32'h0);
        check("byte_lane3", dout_b, 32'h7722_2222);

        // Reset with nonzero outputs; the write issued under reset must be dropped.
        tick(1'b0, 1'b1, 2'd0, 15'h300, 32'h0, 1'b1, 2'd0, 15'h100, 32'h0);
        tick(1'b1, 1'b1, 2'd0, 15'h300, 32'h0, 1'b1, 2'd3, 15'h100, 32'h0BAD_0BAD);
        check("rst_a", dout_a, 32'h0000_0000);
        check("rst_b", dout_b, 32'h0000_0000);
        tick(1'b0, 1'b1, 2'd0, 15'h100, 32'h0, 1'b0, 2'd0, 15'h0, 32'h0);
        check("survives_rst", dout_a, 32'hDE55_1234);

        // Deselected write is ignored and output holds; a selected write also holds output.
        tick(1'b0, 1'b0, 2'd0, 15'h0, 32'h0, 1'b1, 2'd0, 15'h200, 32'h0);
        tick(1'b0, 1'b0, 2'd0, 15'h0, 32'h0, 1'b0, 2'd3, 15'h200, 32'h9999_9999);
        check("cs_hold_b", dout_b, 32'h7722_2222);
        tick(1'b0, 1'b1, 2'd0, 15'h200, 32'h0, 1'b1, 2'd3, 15'h400, 32'h1357_9BDF);
        check("cs_no_write", dout_a, 32'h7722_2222);
        check("write_hold_b", dout_b, 32'h7722_2222);
        tick(1'b0, 1'b1, 2'd0, 15'h402, 32'h0, 1'b0, 2'd0, 15'h0, 32'h0);
        check("read_unaligned", dout_a, 32'h1357_9BDF);
        idle();
        check("idle_hold_a", dout_a, 32'h1357_9BDF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
